// File: rtl/game_tick_gen.sv
// Programmable game tick generator with run/pause, single-step handshake and tick counter.
// Optional GAME_TICK_SAT_EN: tick_count saturates at all-ones and a sticky cnt_sat output is added.
module game_tick_gen #(
    parameter int unsigned BASE_DIV = 50,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [1:0]       speed,
    input  logic             step_req,
    output logic             step_ack,
    output logic             tick,
    output logic [CNT_W-1:0] tick_count,
`ifdef GAME_TICK_SAT_EN
    output logic             cnt_sat,
`endif
    output logic             running
);

    localparam int unsigned DIV_W = $clog2(BASE_DIV + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STEP_ACK = 2'd2
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] period;
    logic             wrap_due;
    logic             tick_next;
    logic [CNT_W-1:0] count_inc;

    // Period for a speed setting; a shift that underflows to zero runs at one clk per tick.
    function automatic logic [DIV_W-1:0] period_of(input logic [1:0] s);
        int unsigned p;
        p = BASE_DIV >> s;
        if (p == 0) begin
            p = 1;
        end
        return DIV_W'(p);
    endfunction

    always_comb begin
        wrap_due  = (div_cnt == (period - DIV_W'(1)));
        tick_next = ((state == IDLE) && !run && step_req) ||
                    ((state == RUN) && run && wrap_due);
`ifdef GAME_TICK_SAT_EN
        count_inc = (tick_count == {CNT_W{1'b1}}) ? tick_count : tick_count + CNT_W'(1);
`else
        count_inc = tick_count + CNT_W'(1);
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            div_cnt  <= '0;
            period   <= period_of(2'd0);
            tick     <= 1'b0;
            step_ack <= 1'b0;
            running  <= 1'b0;
        end else begin
            tick <= tick_next;
            case (state)
                IDLE: begin
                    if (run) begin
                        state   <= RUN;
                        div_cnt <= '0;
                        period  <= period_of(speed);
                        running <= 1'b1;
                    end else if (step_req) begin
                        state    <= STEP_ACK;
                        step_ack <= 1'b1;
                    end
                end
                RUN: begin
                    if (!run) begin
                        // Pause wins over a pending wrap: no tick on this edge.
                        state   <= IDLE;
                        div_cnt <= '0;
                        running <= 1'b0;
                    end else if (wrap_due) begin
                        div_cnt <= '0;
                        period  <= period_of(speed);
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                STEP_ACK: begin
                    if (!step_req) begin
                        state    <= IDLE;
                        step_ack <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_count <= '0;
        end else if (tick_next) begin
            tick_count <= count_inc;
        end
    end

`ifdef GAME_TICK_SAT_EN
    // Sticky flag raised on the tick that first reaches all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_sat <= 1'b0;
        end else if (tick_next && (count_inc == {CNT_W{1'b1}})) begin
            cnt_sat <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_game_tick_gen.sv
// Scoreboard bench for game_tick_gen: a cycle-level reference model queues expected outputs,
// a monitor compares them against the DUT one time step after every rising edge.
module tb_game_tick_gen;

    localparam int unsigned BASE_DIV = 4;
    localparam int unsigned CNT_W    = 4;
    localparam int          CNT_MAX  = (1 << CNT_W) - 1;

    logic             clk      = 1'b0;
    logic             reset    = 1'b1;
    logic             run      = 1'b0;
    logic [1:0]       speed    = 2'd0;
    logic             step_req = 1'b0;
    logic             step_ack;
    logic             tick;
    logic             running;
    logic [CNT_W-1:0] tick_count;
    logic             cnt_sat;

    game_tick_gen #(.BASE_DIV(BASE_DIV), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .speed      (speed),
        .step_req   (step_req),
        .step_ack   (step_ack),
        .tick       (tick),
        .tick_count (tick_count),
`ifdef GAME_TICK_SAT_EN
        .cnt_sat    (cnt_sat),
`endif
        .running    (running)
    );

`ifndef GAME_TICK_SAT_EN
    assign cnt_sat = 1'b0;
`endif

    always #5 clk = ~clk;

    typedef struct {
        logic tick;
        logic ack;
        logic running;
        int   count;
        logic sat;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
        end
    endtask

    function automatic int period_for(input int s);
        int p;
        p = BASE_DIV / (1 << s);
        return (p < 1) ? 1 : p;
    endfunction

    // Reference model: mode 0 paused, 1 running, 2 waiting for step_req to drop.
    int   mode      = 0;
    int   remaining = 0;
    int   total     = 0;
    logic m_tick    = 1'b0;
    logic m_ack     = 1'b0;
    logic m_run     = 1'b0;

    always @(posedge clk) begin
        exp_t e;
        if (reset) begin
            mode = 0; total = 0; remaining = 0;
            m_tick = 1'b0; m_ack = 1'b0; m_run = 1'b0;
        end else begin
            m_tick = 1'b0;
            if (mode == 1) begin
                if (!run) begin
                    mode = 0; m_run = 1'b0;
                end else begin
                    remaining--;
                    if (remaining == 0) begin
                        m_tick = 1'b1; total++;
                        remaining = period_for(int'(speed));
                    end
                end
            end else if (mode == 2) begin
                if (!step_req) begin
                    mode = 0; m_ack = 1'b0;
                end
            end else begin
                if (run) begin
                    mode = 1; m_run = 1'b1;
                    remaining = period_for(int'(speed));
                end else if (step_req) begin
                    mode = 2; m_ack = 1'b1; m_tick = 1'b1; total++;
                end
            end
        end
        e.tick    = m_tick;
        e.ack     = m_ack;
        e.running = m_run;
`ifdef GAME_TICK_SAT_EN
        e.count = (total >= CNT_MAX) ? CNT_MAX : total;
        e.sat   = (total >= CNT_MAX);
`else
        e.count = total % (CNT_MAX + 1);
        e.sat   = 1'b0;
`endif
        q.push_back(e);
    end

    // Monitor: compare the DUT against the queued expectation for this edge.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            chk("scoreboard_empty", 0, 1);
        end else begin
            e = q.pop_front();
            chk("tick", int'(tick), int'(e.tick));
            chk("step_ack", int'(step_ack), int'(e.ack));
            chk("running", int'(running), int'(e.running));
            chk("tick_count", int'(tick_count), e.count);
            chk("cnt_sat", int'(cnt_sat), int'(e.sat));
        end
    end

    task automatic chk_zero(input string where);
        chk({where, "_tick"}, int'(tick), 0);
        chk({where, "_step_ack"}, int'(step_ack), 0);
        chk({where, "_running"}, int'(running), 0);
        chk({where, "_tick_count"}, int'(tick_count), 0);
        chk({where, "_cnt_sat"}, int'(cnt_sat), 0);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        bit seen;
        cycles(2);
        reset = 1'b0;

        // Free run at speed 0, then a mid-period speed change, then period forced to 1.
        run = 1'b1;
        cycles(14);
        speed = 2'd1;
        cycles(10);
        speed = 2'd3;
        cycles(20);

        // Drop run exactly on the edge a wrap is due.
        speed = 2'd0;
        seen  = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cycles(1);
            if (tick) seen = 1'b1;
        end
        cycles(8);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cycles(1);
            if (tick) seen = 1'b1;
        end
        if (!seen) chk("tick_timeout", 0, 1);
        cycles(3);
        run = 1'b0;
        cycles(3);
        run = 1'b1;
        cycles(6);
        run = 1'b0;
        cycles(2);

        // Single-step handshake, then run and step together.
        step_req = 1'b1;
        cycles(3);
        step_req = 1'b0;
        cycles(3);
        run = 1'b1; step_req = 1'b1;
        cycles(3);
        step_req = 1'b0;
        cycles(2);

        // Asynchronous reset in RUN.
        cycles(5);
        #2 reset = 1'b1;
        #1 chk_zero("rst_run");
        cycles(1);
        reset = 1'b0; run = 1'b0;
        cycles(3);

        // Asynchronous reset in STEP_ACK.
        step_req = 1'b1;
        cycles(3);
        #2 reset = 1'b1; step_req = 1'b0;
        #1 chk_zero("rst_step");
        cycles(1);
        reset = 1'b0;
        cycles(3);

        // Randomised run/step/speed traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            cycles(1);
            reset = 1'b0;
            if ($urandom_range(0, 15) == 0) run = ~run;
            if ($urandom_range(0, 7) == 0) step_req = ~step_req;
            if ($urandom_range(0, 31) == 0) speed = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 399) == 0) reset = 1'b1;
        end
        cycles(1);
        reset = 1'b0;
        cycles(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
